restoring_divider: RTL and testbench
====================================

Name: restoring_divider

Overview:
- Sequential unsigned restoring divider; the inverse of the team's shift-add multiplier datapath.
- Uses a left-shifting partial-remainder/quotient register pair, the opposite shift direction of the multiplier's right-shifting accumulator.
- Resolves one quotient bit per clock and uses a start/busy/done handshake.
- Sits beside the multiplier in multiplication_devices as the divide unit.

Parameters:
WIDTH, 8, bit width of dividend, divisor, quotient and remainder (>= 2)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
dividend  input  WIDTH  numerator, captured on accepted start
divisor  input  WIDTH  denominator, captured on accepted start
busy  output  1  high from cycle after accepted start until done cycle inclusive
done  output  1  single-cycle pulse, result valid
quotient  output  WIDTH  result, held until next accepted start
remainder  output  WIDTH  result, held until next accepted start
div_by_zero  output  1  set with done when divisor was 0; held with results

Behaviour:
- Reset values (asynchronous, active-low): state=IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, internal counter and registers 0.
- States:
  - IDLE: start=1 accepted. Capture operands and clear div_by_zero. If divisor==0, go to DONE. Else set R=0 (WIDTH+1 bits), Q=dividend, D=divisor, cnt=WIDTH-1, go to CALC.
  - CALC, once per cycle:
    - T = {R[WIDTH-1:0], Q[WIDTH-1]}.
    - If T >= {1'b0,D}: R = T - D and Q = {Q[WIDTH-2:0],1}.
    - Else: R = T and Q = {Q[WIDTH-2:0],0}.
    - If cnt==0, go to DONE; else cnt-1.
  - DONE: register quotient=Q and remainder=R[WIDTH-1:0], done=1, then go to IDLE.
    - Divide-by-zero case: quotient={WIDTH{1}}, remainder=dividend, div_by_zero=1.
- Latency: start sampled at edge 0 gives done=1 during cycle WIDTH+1. The divide-by-zero path gives done during cycle 1.
- busy=1 in CALC and DONE. start while busy is ignored with no side effects.
- A new start is accepted the cycle after done (IDLE). Back-to-back throughput is WIDTH+2 cycles.
- Boundaries:
  - divisor > dividend: quotient=0, remainder=dividend.
  - divisor==1: quotient=dividend, remainder=0.
  - dividend==0: quotient=0, remainder=0.
- Arithmetic: R is WIDTH+1 bits, so the compare never overflows. Remainder is always < divisor.
- Reset mid-operation aborts immediately. All outputs return to reset values and no done is issued.
- Outputs change only in the DONE cycle (or on reset).

Optional Feature:
- Macro DIV_SIGNED_EN.
- Defined: operands are two's-complement signed.
  - Magnitudes are taken at capture and the CALC iteration is unchanged.
  - In DONE, quotient is negated if operand signs differ, and remainder takes the sign of dividend.
  - Latency is unchanged.
  - Divide by zero: quotient = dividend<0 ? 1 : {WIDTH{1}} (all-ones, i.e. -1, for non-negative dividends); remainder=dividend.
  - Most-negative dividend / -1: quotient = most-negative value (wraps), remainder=0, div_by_zero=0.
- Undefined: purely unsigned behaviour as above; no sign logic synthesised.

Test Plan:
- WIDTH=8, start with 100/7 -> busy next cycle; done pulse exactly 9 cycles after start edge; quotient=14, remainder=2, div_by_zero=0.
- 255/1, then 3/200, then 0/5 back-to-back (each start the cycle after done) -> 255 r0, 0 r3, 0 r0; no lost or duplicated done.
- 5/0 -> done 1 cycle after start; quotient=8'hFF, remainder=5, div_by_zero=1. Next 9/3 -> 3 r0 with div_by_zero cleared.
- Start 200/9, pulse start with 10/2 at cycle 4 -> ignored; result 22 r2 at cycle 9.
- Start 200/9, assert rst_n=0 at cycle 5 -> outputs 0 asynchronously, no done. After release, 50/5 -> 10 r0.
- With DIV_SIGNED_EN:
  - -100/7 -> quotient 8'hF2 (-14), remainder 8'hFE (-2).
  - 100/-7 -> 8'hF2 r2.
  - -128/-1 -> 8'h80 r0.

Source files
------------

// File: rtl/restoring_divider.sv
// Sequential restoring divider: one quotient bit per clock behind a start/busy/done handshake.
// Define DIV_SIGNED_EN for two's-complement operands (magnitude divide plus sign fix-up).
module restoring_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;
  logic             done_q, done_d;
  logic [WIDTH:0]   trial;

`ifdef DIV_SIGNED_EN
  logic dvd_neg_q, dvd_neg_d;
  logic q_neg_q, q_neg_d;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? -v : v;
  endfunction
`endif

  // R only ever holds values below D, so its stored top bit is always zero;
  // the extra bit lives in the shifted trial value used for the compare.
  assign trial = {rem_q, quo_q[WIDTH-1]};

  always_comb begin
    // NOTE: every next-state signal gets its hold value first so no path infers a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    done_d      = 1'b0;
`ifdef DIV_SIGNED_EN
    dvd_neg_d   = dvd_neg_q;
    q_neg_d     = q_neg_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          dbz_d = 1'b0;
          rem_d = '0;
          cnt_d = CNT_LAST;
`ifdef DIV_SIGNED_EN
          quo_d     = mag(dividend);
          dvs_d     = mag(divisor);
          dvd_neg_d = dividend[WIDTH-1];
          q_neg_d   = dividend[WIDTH-1] ^ divisor[WIDTH-1];
`else
          quo_d = dividend;
          dvs_d = divisor;
`endif
          state_d = (divisor == '0) ? DONE : CALC;
        end
      end
      CALC: begin
        if (trial >= {1'b0, dvs_q}) begin
          rem_d = WIDTH'(trial - {1'b0, dvs_q});
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = trial[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        if (cnt_q == '0) state_d = DONE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
        // A zero divisor skips CALC, so quo_q still holds the captured dividend.
        if (dvs_q == '0) begin
          dbz_d = 1'b1;
`ifdef DIV_SIGNED_EN
          quotient_d  = dvd_neg_q ? WIDTH'(1) : '1;
          remainder_d = dvd_neg_q ? -quo_q : quo_q;
`else
          quotient_d  = '1;
          remainder_d = quo_q;
`endif
        end else begin
`ifdef DIV_SIGNED_EN
          quotient_d  = q_neg_q ? -quo_q : quo_q;
          remainder_d = dvd_neg_q ? -rem_q : rem_q;
`else
          quotient_d  = quo_q;
          remainder_d = rem_q;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
      done_q      <= 1'b0;
`ifdef DIV_SIGNED_EN
      dvd_neg_q   <= 1'b0;
      q_neg_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
      done_q      <= done_d;
`ifdef DIV_SIGNED_EN
      dvd_neg_q   <= dvd_neg_d;
      q_neg_q     <= q_neg_d;
`endif
    end
  end

  // Busy spans the working states plus the registered done cycle.
  assign busy        = (state_q != IDLE) || done_q;
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_restoring_divider.sv
// Scoreboard bench for restoring_divider: directed vectors push expectations,
// a monitor pops and compares on every done pulse.
module tb_restoring_divider;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    int           lat;
    int           sc;
    string        name;
  } exp_t;

  exp_t sb[$];

  restoring_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", {31'b0, done}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check({e.name, "_q"},   {24'b0, quotient},    {24'b0, e.q});
        check({e.name, "_r"},   {24'b0, remainder},   {24'b0, e.r});
        check({e.name, "_dbz"}, {31'b0, div_by_zero}, {31'b0, e.dbz});
        check({e.name, "_lat"}, cyc - e.sc,           e.lat);
      end
    end
  end

  // Called at a negedge: drives start for one edge, logs the expectation.
  task automatic do_div(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] q, input logic [W-1:0] r, input logic dbz);
    exp_t e;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    e.q    = q;
    e.r    = r;
    e.dbz  = dbz;
    e.lat  = dbz ? 1 : W + 1;
    e.sc   = cyc;
    e.name = name;
    sb.push_back(e);
    @(negedge clk);
    check({name, "_busy"}, {31'b0, busy}, 32'd1);
  endtask

  // Returns at the negedge where done is seen; an expired budget counts as a failure.
  task automatic wait_done(input string name);
    for (int i = 0; i < 40; i++) begin
      if (done) return;
      @(negedge clk);
    end
    check({name, "_timeout"}, {31'b0, done}, 32'd1);
  endtask

  initial begin
    #12;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_q",    {24'b0, quotient}, 32'd0);
    check("rst_r",    {24'b0, remainder}, 32'd0);
    check("rst_dbz",  {31'b0, div_by_zero}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    do_div("d100_7", 8'd100, 8'd7, 8'd14, 8'd2, 1'b0);
    wait_done("d100_7");
    @(negedge clk);

    // Back-to-back: each new start issued in the done cycle's IDLE slot.
    do_div("d255_1", 8'd255, 8'd1, 8'd255, 8'd0, 1'b0);
    wait_done("d255_1");
    do_div("d3_200", 8'd3, 8'd200, 8'd0, 8'd3, 1'b0);
    wait_done("d3_200");
    do_div("d0_5", 8'd0, 8'd5, 8'd0, 8'd0, 1'b0);
    wait_done("d0_5");
    @(negedge clk);

    do_div("d5_0", 8'd5, 8'd0, 8'hFF, 8'd5, 1'b1);
    wait_done("d5_0");
    @(negedge clk);
    do_div("d9_3", 8'd9, 8'd3, 8'd3, 8'd0, 1'b0);
    wait_done("d9_3");
    @(negedge clk);

    // Start pulse during CALC must be ignored.
`ifdef DIV_SIGNED_EN
    do_div("d200_9", 8'd200, 8'd9, 8'hFA, 8'hFE, 1'b0);
`else
    do_div("d200_9", 8'd200, 8'd9, 8'd22, 8'd2, 1'b0);
`endif
    repeat (3) @(negedge clk);
    dividend = 8'd10;
    divisor  = 8'd2;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("hold_q", {24'b0, quotient}, 32'd3);
    wait_done("d200_9");
    @(negedge clk);

    // Reset mid-operation aborts without a done.
    do_div("abort", 8'd200, 8'd9, 8'd22, 8'd2, 1'b0);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    sb.delete();
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_done", {31'b0, done}, 32'd0);
    check("abort_q",    {24'b0, quotient}, 32'd0);
    check("abort_r",    {24'b0, remainder}, 32'd0);
    check("abort_dbz",  {31'b0, div_by_zero}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    do_div("d50_5", 8'd50, 8'd5, 8'd10, 8'd0, 1'b0);
    wait_done("d50_5");
    @(negedge clk);

`ifdef DIV_SIGNED_EN
    do_div("sm100_7", 8'h9C, 8'd7, 8'hF2, 8'hFE, 1'b0);
    wait_done("sm100_7");
    @(negedge clk);
    do_div("s100_m7", 8'd100, 8'hF9, 8'hF2, 8'd2, 1'b0);
    wait_done("s100_m7");
    @(negedge clk);
    do_div("sm128_m1", 8'h80, 8'hFF, 8'h80, 8'd0, 1'b0);
    wait_done("sm128_m1");
    @(negedge clk);
    do_div("sm5_0", 8'hFB, 8'd0, 8'd1, 8'hFB, 1'b1);
    wait_done("sm5_0");
    @(negedge clk);
`endif

    repeat (3) @(negedge clk);
    check("sb_empty", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
